// File: rtl/mux_2x1_rr_arbiter.sv
// Two-source valid/ready arbiter feeding a one-entry output buffer and 2:1 select S.
// Define ARB_STRICT_PRIO_EN for fixed X1 priority; round-robin otherwise.
module mux_2x1_rr_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             X1_valid,
   input  logic [WIDTH-1:0] X1_data,
   output logic             X1_ready,
   input  logic             X2_valid,
   input  logic [WIDTH-1:0] X2_data,
   output logic             X2_ready,
   output logic             S,
   output logic             F_valid,
   output logic [WIDTH-1:0] F_data,
   input  logic             F_ready
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_q, sel_d;
   logic             last_q, last_d;
   logic             load_en;
   logic             any_valid;
   logic             grant;

   assign load_en   = (state_q == EMPTY) || (F_ready && (state_q == FULL));
   assign any_valid = X1_valid || X2_valid;

   // grant: 0 selects X1, 1 selects X2 (same encoding as S)
   always_comb begin
      grant = 1'b0;
      if (X1_valid && X2_valid) begin
`ifdef ARB_STRICT_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_q;
`endif
      end else if (X2_valid) begin
         grant = 1'b1;
      end
   end

   // readies are forced low while reset is held, even though load_en is high in EMPTY
   assign X1_ready = ~rst && load_en && ~grant && X1_valid;
   assign X2_ready = ~rst && load_en &&  grant && X2_valid;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      last_d  = last_q;
      if (load_en) begin
         if (any_valid) begin
            state_d = FULL;
            data_d  = grant ? X2_data : X1_data;
            sel_d   = grant;
            last_d  = grant;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   assign F_valid = (state_q == FULL);
   assign F_data  = data_q;
   assign S       = sel_q;

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed self-checking bench for mux_2x1_rr_arbiter (default and ARB_STRICT_PRIO_EN builds).
module tb_mux_2x1_rr_arbiter;

   logic       clk;
   logic       rst;
   logic       X1_valid, X2_valid;
   logic [7:0] X1_data, X2_data;
   logic       X1_ready, X2_ready;
   logic       S, F_valid, F_ready;
   logic [7:0] F_data;

   int unsigned total;
   int unsigned bad;

   logic       acc1, acc2;
   logic [7:0] exp_ctn_d [4];
   logic       exp_ctn_s [4];
   logic [7:0] exp_bp_d;
   logic       exp_bp_s;

   mux_2x1_rr_arbiter #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .X1_valid (X1_valid),
      .X1_data  (X1_data),
      .X1_ready (X1_ready),
      .X2_valid (X2_valid),
      .X2_data  (X2_data),
      .X2_ready (X2_ready),
      .S        (S),
      .F_valid  (F_valid),
      .F_data   (F_data),
      .F_ready  (F_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
`ifdef ARB_STRICT_PRIO_EN
      exp_ctn_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      exp_ctn_s = '{1'b0, 1'b0, 1'b0, 1'b0};
      exp_bp_d  = 8'h44;
      exp_bp_s  = 1'b0;
`else
      exp_ctn_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
      exp_ctn_s = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_bp_d  = 8'h55;
      exp_bp_s  = 1'b1;
`endif

      // reset state; readies gated even with a valid source
      rst = 1'b1; X1_valid = 1'b1; X1_data = 8'h11; X2_valid = 1'b0; X2_data = 8'h00; F_ready = 1'b1;
      #2;
      chk1("rst_fvalid", F_valid, 1'b0);
      chk8("rst_fdata", F_data, 8'h00);
      chk1("rst_s", S, 1'b0);
      chk1("rst_x1rdy", X1_ready, 1'b0);

      // single source X1
      tick();
      rst = 1'b0;
      #1;
      chk1("single_x1rdy", X1_ready, 1'b1);
      chk1("single_x2rdy", X2_ready, 1'b0);
      tick();
      X1_valid = 1'b0;
      chk1("single_fvalid", F_valid, 1'b1);
      chk8("single_fdata", F_data, 8'h11);
      chk1("single_s", S, 1'b0);
      tick();
      chk1("drain_fvalid", F_valid, 1'b0);
      chk8("drain_fdata_hold", F_data, 8'h11);
      chk1("drain_s_hold", S, 1'b0);

      // async reset mid-run with a buffered word
      X1_valid = 1'b1; X1_data = 8'h33; F_ready = 1'b0;
      tick();
      chk1("pre_rst_fvalid", F_valid, 1'b1);
      chk8("pre_rst_fdata", F_data, 8'h33);
      #3;
      rst = 1'b1;
      #1;
      chk1("async_rst_fvalid", F_valid, 1'b0);
      chk8("async_rst_fdata", F_data, 8'h00);
      chk1("async_rst_s", S, 1'b0);
      chk1("async_rst_x1rdy", X1_ready, 1'b0);
      tick();

      // contention: fairness restarts with X1
      rst = 1'b0;
      X1_valid = 1'b1; X1_data = 8'hA0;
      X2_valid = 1'b1; X2_data = 8'hB0;
      F_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("ctn_x1rdy", X1_ready, ~exp_ctn_s[i]);
         chk1("ctn_x2rdy", X2_ready, exp_ctn_s[i]);
         acc1 = X1_ready;
         acc2 = X2_ready;
         tick();
         if (acc1) X1_data = X1_data + 8'h01;
         if (acc2) X2_data = X2_data + 8'h01;
         chk1("ctn_fvalid", F_valid, 1'b1);
         chk8("ctn_fdata", F_data, exp_ctn_d[i]);
         chk1("ctn_s", S, exp_ctn_s[i]);
      end

      // backpressure: hold 0x22 for 3 stalled cycles
      X1_valid = 1'b1; X1_data = 8'h22; X2_valid = 1'b0;
      tick();
      chk8("bp_load_fdata", F_data, 8'h22);
      chk1("bp_load_s", S, 1'b0);
      F_ready = 1'b0;
      X1_data = 8'h44; X2_valid = 1'b1; X2_data = 8'h55;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("bp_x1rdy", X1_ready, 1'b0);
         chk1("bp_x2rdy", X2_ready, 1'b0);
         tick();
         chk1("bp_fvalid", F_valid, 1'b1);
         chk8("bp_fdata", F_data, 8'h22);
         chk1("bp_s", S, 1'b0);
      end
      F_ready = 1'b1;
      #1;
      chk1("bp_rel_x1rdy", X1_ready, ~exp_bp_s);
      chk1("bp_rel_x2rdy", X2_ready, exp_bp_s);
      tick();
      chk8("bp_rel_fdata", F_data, exp_bp_d);
      chk1("bp_rel_s", S, exp_bp_s);

      // throughput: X2-only stream, no bubbles
      X1_valid = 1'b0; X2_valid = 1'b1; X2_data = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk1("tput_x2rdy", X2_ready, 1'b1);
         tick();
         X2_data = X2_data + 8'h01;
         chk1("tput_fvalid", F_valid, 1'b1);
         chk8("tput_fdata", F_data, 8'(i));
         chk1("tput_s", S, 1'b1);
      end
      X2_valid = 1'b0;
      tick();
      chk1("end_fvalid", F_valid, 1'b0);
      chk8("end_fdata_hold", F_data, 8'h08);
      chk1("end_s_hold", S, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
Upstream control stage for the 2:1 select path. Arbitrates between two valid/ready sources (X1, X2) with round-robin fairness, registers the winning word into a one-entry output buffer, and drives select S with the same encoding as the 2:1 mux (S=0 -> X1, S=1 -> X2). Downstream sees a single valid/ready stream F with 1-cycle latency and full throughput.

Parameters:
WIDTH, 8, data width of X1_data, X2_data, F_data

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
X1_valid  input  1  source 1 has data
X1_data  input  WIDTH  source 1 data
X1_ready  output  1  source 1 word accepted this cycle
X2_valid  input  1  source 2 has data
X2_data  input  WIDTH  source 2 data
X2_ready  output  1  source 2 word accepted this cycle
S  output  1  registered select: source of the word in F_data (0=X1, 1=X2)
F_valid  output  1  output buffer holds a word
F_data  output  WIDTH  registered output word
F_ready  input  1  downstream accepts F_data

Behaviour:
- Reset (async, rst=1): F_valid=0, F_data=0, S=0, last_grant=1 (X1 wins the first contention); state=EMPTY. X1_ready/X2_ready read 0 while rst=1.
- States: EMPTY (F_valid=0), FULL (F_valid=1).
- load_en = (state==EMPTY) | (F_ready & F_valid).
- Grant (combinational):
  - only X1_valid -> grant X1; only X2_valid -> grant X2.
  - both valid -> grant the input not equal to last_grant.
  - neither -> no grant.
- Xn_ready = load_en & (grant==n) & Xn_valid; at most one ready high per cycle.
- On a clock edge with a load (load_en & any valid): F_data <= granted data, S <= grant, last_grant <= grant, F_valid <= 1 (state FULL).
- Load_en with no valid: F_valid <= 0 (state EMPTY); F_data and S hold their previous values.
- FULL & ~F_ready: F_data, S, F_valid hold; both readies 0 (backpressure; no word dropped or overwritten).
- Simultaneous drain and load in FULL: the word is replaced on the same edge; no bubble; sustained 1 word/cycle.
- Latency: input accept edge -> F_valid high on the next cycle.
- last_grant updates only on an actual load; it does not update on idle or stall cycles.
- Reset mid-transfer: the buffered word is discarded, and fairness restarts with X1 priority.
- Unloaded Xn_data is don't-care; sources must hold data while valid and not ready (standard valid/ready rule).

Optional Feature:
ARB_STRICT_PRIO_EN
- Defined: fixed priority. X1 always wins when both are valid. last_grant is still maintained but ignored by the grant logic. X2 may starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset: assert rst mid-run with F_valid=1 -> F_valid=0, F_data=0, S=0 immediately, without waiting for clk.
- Single source: X1_valid=1, X1_data=0x11, F_ready=1 -> X1_ready=1; next cycle F_valid=1, F_data=0x11, S=0.
- Contention fairness: both valid continuously (X1=0xA0.., X2=0xB0..), F_ready=1 -> outputs alternate 0xA0, 0xB0, 0xA1, 0xB1; S toggles 0,1,0,1; first grant is X1.
- Backpressure: FULL with F_data=0x22, F_ready=0 for 3 cycles, both sources valid -> both readies 0, F_data=0x22 and S held; on F_ready=1, a new word loads the same cycle.
- Throughput: X2-only stream 0x01..0x08 with F_ready=1 -> 8 consecutive output cycles with no bubble, S=1 throughout.
- ARB_STRICT_PRIO_EN build: both valid for 4 cycles -> 4 X1 words, X2_ready never asserted.
